mmio_responder: RTL and testbench

//  Memory-mapped IO target that serves the io_en accesses issued by the MEM stage (addr[31:28] == ADDR_IO).

---
 rtl/mmio_responder_pkg.sv | 41 ++++
 rtl/mmio_responder_io_tx_fifo.sv | 83 ++++++++
 rtl/mmio_responder.sv | 173 +++++++++++++++++
 tb/tb_mmio_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_responder_pkg.sv
// ---------------------------------------------------------------------------
// mmio_responder_pkg
// Shared definitions for the MMIO responder: register offsets decoded from
// addr[7:0], STATUS bit positions and layout, and the MEM_SIZE_* encodings
// used by the MEM stage.
// ---------------------------------------------------------------------------
package mmio_responder_pkg;

   // Access size encodings driven by the MEM stage
   localparam logic [1:0] MEM_SIZE_BYTE      = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF      = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD      = 2'd2;
   localparam logic [1:0] MEM_SIZE_UNDEFINED = 2'd3;

   // Register offsets within the IO window (addr[7:0])
   localparam logic [7:0] IO_STATUS  = 8'h00;
   localparam logic [7:0] IO_RX      = 8'h04;
   localparam logic [7:0] IO_TX      = 8'h08;
   localparam logic [7:0] IO_CYCLES  = 8'h10;
   localparam logic [7:0] IO_INSTS   = 8'h14;
   localparam logic [7:0] IO_CNT_RST = 8'h18;

   // STATUS bit indices
   localparam int STATUS_TX_NFULL = 0;
   localparam int STATUS_RX_FULL  = 1;
   localparam int STATUS_OVF      = 2;

   // STATUS word layout; field order matches the bit indices above
   typedef struct packed {
      logic [28:0] rsvd;
      logic        ovf;
      logic        rx_full;
      logic        tx_not_full;
   } status_t;

   // A store with an undefined size has no effect on any register
   function automatic logic is_defined_size(input logic [1:0] size);
      return size != MEM_SIZE_UNDEFINED;
   endfunction

endpackage

// File: rtl/mmio_responder_io_tx_fifo.sv
// ---------------------------------------------------------------------------
// io_tx_fifo
// First-word-fall-through FIFO feeding the UART transmitter. o_dout is valid
// whenever o_empty is low. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; a push into an empty FIFO becomes visible
// on the following cycle (no combinational bypass to o_dout/o_empty).
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous active-high reset (empties the FIFO)
//   i_push   in   write request
//   i_din    in   WIDTH  write data
//   o_full   out  FIFO holds DEPTH entries
//   i_pop    in   read request (ignored while empty)
//   o_dout   out  WIDTH  head entry
//   o_empty  out  FIFO holds no entries
// ---------------------------------------------------------------------------
module io_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_full,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty
);

   localparam int               PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_COUNT);
   assign o_dout  = r_mem[r_rd_ptr];

   // The pop frees the slot the push needs, so a full FIFO still accepts.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // NOTE: storage has no reset; resetting the pointers and count is enough to
   // discard its contents, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // NOTE: non-blocking assignments in clocked blocks so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// ---------------------------------------------------------------------------
// mmio_responder
// Memory-mapped IO target for io_en accesses from the MEM stage. Holds the
// UART TX FIFO, the RX holding register and the cycle / retired-instruction
// counters. Load data appears on rdata one cycle after the request, matching
// the block-RAM timing of BIOS/DMEM.
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   io_en     in   IO access this cycle
//   we        in   1 = store, 0 = load
//   addr      in   32  byte address; only addr[7:0] is decoded
//   size      in   2   MEM_SIZE_*; an undefined-size store is a no-op
//   wdata     in   32  store data, lane 0 aligned
//   retire    in   one pulse per retired instruction
//   rdata     out  32  load data, registered
//   tx_data   out  8   byte to UART transmitter
//   tx_valid  out  tx_data valid
//   tx_ready  in   transmitter accepts
//   rx_data   in   8   byte from UART receiver
//   rx_valid  in   rx_data valid
//   rx_ready  out  RX holding register empty
// ---------------------------------------------------------------------------
module mmio_responder
   import mmio_responder_pkg::*;
#(
   parameter int TX_DEPTH = 4,
   parameter int CNT_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_en,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   input  logic        retire,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [31:0]      r_rdata;
   logic             r_ovf;
   logic             r_rx_full;
   logic [7:0]       r_rx_byte;
   logic [CNT_W-1:0] r_cycles;
   logic [CNT_W-1:0] r_insts;

   logic [7:0]  w_offset;
   logic        w_rd;
   logic        w_wr;
   logic        w_tx_push;
   logic        w_tx_pop;
   logic        w_tx_full;
   logic        w_tx_empty;
   logic        w_cnt_clr;
   logic        w_status_rd;
   logic        w_rx_rd;
   logic        w_rx_accept;
   logic        w_ovf_set;
   status_t     w_status;
   logic [31:0] w_rd_val;
   logic        w_unused;

   // Only the low byte of the address and of the store data are meaningful
   assign w_unused = ^{addr[31:8], wdata[31:8]};

   // ---------------- decode ----------------
   assign w_offset    = addr[7:0];
   assign w_rd        = io_en && !we;
   assign w_wr        = io_en && we && is_defined_size(size);
   assign w_tx_push   = w_wr && (w_offset == IO_TX);
   assign w_cnt_clr   = w_wr && (w_offset == IO_CNT_RST);
   assign w_status_rd = w_rd && (w_offset == IO_STATUS);
   assign w_rx_rd     = w_rd && (w_offset == IO_RX);

   // ---------------- TX FIFO ----------------
   assign tx_valid  = ~w_tx_empty;
   assign w_tx_pop  = tx_valid && tx_ready;
   // A push into a full FIFO is lost only when nothing drains that cycle
   assign w_ovf_set = w_tx_push && w_tx_full && !w_tx_pop;

   io_tx_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_tx_push),
      .i_din   (wdata[7:0]),
      .o_full  (w_tx_full),
      .i_pop   (w_tx_pop),
      .o_dout  (tx_data),
      .o_empty (w_tx_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (w_status_rd) begin
         r_ovf <= 1'b0;
      end
   end

   // ---------------- RX holding register ----------------
   assign rx_ready    = ~r_rx_full;
   assign w_rx_accept = rx_valid && rx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_full <= 1'b0;
         r_rx_byte <= '0;
      end else if (w_rx_accept) begin
         r_rx_full <= 1'b1;
         r_rx_byte <= rx_data;
      end else if (w_rx_rd) begin
         // Reading while empty returns the stale byte and changes nothing
         r_rx_full <= 1'b0;
      end
   end

   // ---------------- counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycles <= '0;
         r_insts  <= '0;
      end else if (w_cnt_clr) begin
         r_cycles <= '0;
         r_insts  <= '0;
      end else begin
         r_cycles <= r_cycles + CNT_ONE;
         r_insts  <= r_insts + CNT_W'(retire);
      end
   end

   // ---------------- read path ----------------
   assign w_status = '{rsvd: '0, ovf: r_ovf, rx_full: r_rx_full, tx_not_full: ~w_tx_full};

   // NOTE: default assigned before the case so every path drives w_rd_val and
   // no latch is inferred.
   always_comb begin
      w_rd_val = '0;
      case (w_offset)
         IO_STATUS: w_rd_val = w_status;
         IO_RX:     w_rd_val = {24'b0, r_rx_byte};
         IO_CYCLES: w_rd_val = 32'(r_cycles);
         IO_INSTS:  w_rd_val = 32'(r_insts);
         default:   ;
      endcase
   end

   // rdata holds its last value between loads, like a block-RAM output port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_rd) begin
         r_rdata <= w_rd_val;
      end
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_mmio_responder
// Directed and randomized stimulus for mmio_responder against a behavioural
// model (queue-based FIFO, plain integer counters). A second instance with
// 4-bit counters shares all inputs and exposes counter wrap-around.
// ---------------------------------------------------------------------------
module tb_mmio_responder;
   import mmio_responder_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        io_en = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [1:0]  size = MEM_SIZE_WORD;
   logic [31:0] wdata = '0;
   logic        retire = 1'b0;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;

   logic [31:0] rdata, rdata2;
   logic [7:0]  tx_data, tx_data2;
   logic        tx_valid, tx_valid2;
   logic        rx_ready, rx_ready2;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Behavioural model state
   logic [7:0]  m_q[$];
   bit          m_ovf;
   bit          m_rx_full;
   logic [7:0]  m_rx_byte;
   logic [31:0] m_cycles;
   logic [31:0] m_insts;
   logic [31:0] m_rdata;
   logic [31:0] m_rdata2;

   always #5 clk = ~clk;

   mmio_responder #(.TX_DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .io_en(io_en), .we(we), .addr(addr), .size(size),
      .wdata(wdata), .retire(retire), .rdata(rdata), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   mmio_responder #(.TX_DEPTH(DEPTH), .CNT_W(4)) dut_cnt4 (
      .clk(clk), .rst(rst), .io_en(io_en), .we(we), .addr(addr), .size(size),
      .wdata(wdata), .retire(retire), .rdata(rdata2), .tx_data(tx_data2),
      .tx_valid(tx_valid2), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] read_val(input logic [7:0] off, input logic [31:0] mask);
      logic [31:0] v = '0;
      case (off)
         8'h00: begin
            v[STATUS_TX_NFULL] = (m_q.size() < DEPTH);
            v[STATUS_RX_FULL]  = m_rx_full;
            v[STATUS_OVF]      = m_ovf;
         end
         8'h04: v = {24'b0, m_rx_byte};
         8'h10: v = m_cycles & mask;
         8'h14: v = m_insts & mask;
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic check_outputs();
      check("rdata", rdata, m_rdata);
      check("rdata_cnt4", rdata2, m_rdata2);
      check("tx_valid", tx_valid, m_q.size() != 0);
      check("tx_valid_cnt4", tx_valid2, m_q.size() != 0);
      if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
      check("rx_ready", rx_ready, !m_rx_full);
   endtask

   // One clock edge: advance the model with the inputs held across the edge
   task automatic tick();
      logic [7:0]  off;
      bit          rd, wr, pop, push, ovf_set;
      logic [31:0] rv, rv2;
      @(posedge clk);
      #1;
      off     = addr[7:0];
      rd      = io_en && !we;
      wr      = io_en && we && (size != MEM_SIZE_UNDEFINED);
      rv      = read_val(off, 32'hFFFF_FFFF);
      rv2     = read_val(off, 32'h0000_000F);
      pop     = tx_ready && (m_q.size() != 0);
      push    = 1'b0;
      ovf_set = 1'b0;
      if (wr && off == 8'h08) begin
         if (m_q.size() < DEPTH || pop) push = 1'b1;
         else ovf_set = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(wdata[7:0]);
      if (rd && off == 8'h00) m_ovf = 1'b0;
      if (ovf_set) m_ovf = 1'b1;
      if (rx_valid && !m_rx_full) begin
         m_rx_full = 1'b1;
         m_rx_byte = rx_data;
      end else if (rd && off == 8'h04) begin
         m_rx_full = 1'b0;
      end
      if (wr && off == 8'h18) begin
         m_cycles = '0;
         m_insts  = '0;
      end else begin
         m_cycles = m_cycles + 1;
         m_insts  = m_insts + 32'(retire);
      end
      if (rd) begin
         m_rdata  = rv;
         m_rdata2 = rv2;
      end
      check_outputs();
   endtask

   task automatic idle();
      io_en = 1'b0;
      we    = 1'b0;
      addr  = '0;
      size  = MEM_SIZE_WORD;
      wdata = '0;
   endtask

   task automatic store(input logic [7:0] off, input logic [31:0] d);
      io_en = 1'b1; we = 1'b1; addr = {24'h800000, off}; size = MEM_SIZE_WORD; wdata = d;
      tick();
      idle();
   endtask

   task automatic load(input logic [7:0] off);
      io_en = 1'b1; we = 1'b0; addr = {24'h800000, off};
      tick();
      idle();
   endtask

   // Asynchronous reset applied between edges, released away from an edge
   task automatic apply_reset();
      idle();
      retire   = 1'b0;
      rx_valid = 1'b0;
      rst      = 1'b1;
      #2;
      m_q.delete();
      m_ovf = 0; m_rx_full = 0; m_rx_byte = '0;
      m_cycles = '0; m_insts = '0; m_rdata = '0; m_rdata2 = '0;
      check("rst_rdata", rdata, 32'h0);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_rx_ready", rx_ready, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got[$];
      int unsigned n;
      logic [7:0] offs [8];
      offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C};

      apply_reset();

      // TX: two bytes queued, then drained in order
      tx_ready = 1'b0;
      store(8'h08, 32'h0000_0041);
      store(8'h08, 32'hFFFF_FF42);
      load(8'h00);
      check("t2_status", rdata, 32'h1);
      check("t2_head0", tx_data, 8'h41);
      tx_ready = 1'b1;
      tick();
      check("t2_head1", tx_data, 8'h42);
      tick();
      check("t2_drained", tx_valid, 1'b0);
      tx_ready = 1'b0;

      // Overflow: fifth push dropped, ovf cleared by the STATUS read
      for (int i = 0; i < 5; i++) store(8'h08, 32'h30 + i);
      load(8'h00);
      check("t3_status_ovf", rdata, 32'h4);
      load(8'h00);
      check("t3_status_clr", rdata, 32'h0);
      tx_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && tx_valid; c++) begin
         n++;
         tick();
      end
      check("t3_drain_count", n, 4);
      check("t3_drain_done", tx_valid, 1'b0);
      tx_ready = 1'b0;

      // RX holding register
      rx_data  = 8'h5A;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      check("t4_rx_ready_low", rx_ready, 1'b0);
      load(8'h00);
      check("t4_status_rx", rdata[STATUS_RX_FULL], 1'b1);
      load(8'h04);
      check("t4_rx_byte", rdata, 32'h5A);
      check("t4_rx_ready_high", rx_ready, 1'b1);

      // Counters
      store(8'h18, 32'h0);
      for (int c = 0; c < 20; c++) begin
         retire = (c % 2 == 0);
         tick();
      end
      retire = 1'b0;
      load(8'h14);
      check("t5_insts", rdata, 32'd10);
      store(8'h18, 32'h0);
      load(8'h10);
      check("t5_cycles_cleared", rdata, 32'd0);
      load(8'h14);
      check("t5_insts_cleared", rdata, 32'd0);
      store(8'h18, 32'h0);
      for (int c = 0; c < 15; c++) tick();
      load(8'h10);
      check("t5_cnt4_allones", rdata2, 32'hF);
      load(8'h10);
      check("t5_cnt4_wrapped", rdata2, 32'h0);
      check("t5_cnt32_nowrap", rdata, 32'd16);

      // Push and pop together on a full FIFO
      for (int i = 0; i < 4; i++) store(8'h08, 32'hA0 + i);
      tx_ready = 1'b1;
      store(8'h08, 32'hA4);
      tx_ready = 1'b0;
      load(8'h00);
      check("t6_status_full_noovf", rdata, 32'h0);
      tx_ready = 1'b1;
      for (int c = 0; c < 20 && tx_valid; c++) begin
         got.push_back(tx_data);
         tick();
      end
      tx_ready = 1'b0;
      check("t6_drain_count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) check("t6_order", got[i], 8'hA1 + 8'(i));

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         io_en    = 1'($urandom_range(0, 1));
         we       = 1'($urandom_range(0, 1));
         addr     = $urandom();
         addr[7:0] = offs[$urandom_range(0, 7)];
         size     = 2'($urandom_range(0, 3));
         wdata    = $urandom();
         retire   = 1'($urandom_range(0, 1));
         tx_ready = ($urandom_range(0, 2) == 0);
         rx_valid = ($urandom_range(0, 3) == 0);
         rx_data  = 8'($urandom());
         tick();
      end
      idle();
      retire   = 1'b0;
      rx_valid = 1'b0;

      // Reset mid-run with bytes in flight
      tx_ready = 1'b0;
      store(8'h08, 32'h11);
      store(8'h08, 32'h22);
      rx_data  = 8'h77;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      apply_reset();
      tick();
      load(8'h10);
      check("t1_cycles_after_reset", rdata, 32'd1);
      check("t1_fifo_empty", tx_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
